// File: rtl/mem_arb2_if.sv
// ---------------------------------------------------------------------------
// mem_arb2_if
//   Bundles every signal between the two-requester memory arbiter, its two
//   datapath clients and the single-port register memory.
//
//   Requester side : reqN, weN, addrN, wdataN  -> arbiter
//                    gntN, rvalidN, rdataN     <- arbiter
//   Memory side    : mem_en, mem_addr, mem_din -> memory
//                    mem_dout, mem_valid       <- memory
//   Status         : busy, rd_err              <- arbiter
//
//   slave  : the arbiter's view (commands in, grants/data/memory command out)
//   master : the environment's view (clients plus memory)
// ---------------------------------------------------------------------------
interface mem_arb2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_valid;
  logic                  busy;
  logic                  rd_err;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mem_dout, mem_valid,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_en, mem_addr, mem_din, busy, rd_err
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mem_dout, mem_valid,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  mem_en, mem_addr, mem_din, busy, rd_err
  );

endinterface

// File: rtl/mem_arb2.sv
// ---------------------------------------------------------------------------
// mem_arb2
//   Round-robin arbiter and sequencer placing two requesters in front of a
//   single-port register memory (EN high = write, EN low = registered read).
//   One command is in flight at a time: a write takes 2 cycles (IDLE, ISSUE),
//   a read takes 3 (IDLE, ISSUE, WAIT). All outputs come from registers.
//
//   Ports
//     CLK  : clock, rising edge
//     RST  : asynchronous, active-high reset
//     bus  : mem_arb2_if.slave -- requester commands, grants, read data,
//            memory command/response, busy and sticky rd_err
// ---------------------------------------------------------------------------
module mem_arb2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic      CLK,
  input  logic      RST,
  mem_arb2_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                state_q,    state_d;
  logic                  ptr_q,      ptr_d;      // requester favoured on contention
  logic                  win_q,      win_d;      // requester owning the command in flight
  logic                  mem_en_q,   mem_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q,  mem_din_d;
  logic                  gnt0_q,     gnt0_d;
  logic                  gnt1_q,     gnt1_d;
  logic                  rvalid0_q,  rvalid0_d;
  logic                  rvalid1_q,  rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q,   rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q,   rdata1_d;
  logic                  busy_q,     busy_d;
  logic                  rd_err_q,   rd_err_d;
  logic                  pick;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch to hold it.
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    mem_en_d   = 1'b0;          // EN is only ever high for the ISSUE cycle of a write
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rd_err_d   = rd_err_q;

    // A lone request wins outright; the pointer only breaks ties.
    pick = (bus.req0 && bus.req1) ? ptr_q : bus.req1;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d    = ISSUE;
          win_d      = pick;
          ptr_d      = ~pick;
          gnt0_d     = ~pick;
          gnt1_d     = pick;
          mem_en_d   = pick ? bus.we1    : bus.we0;
          mem_addr_d = pick ? bus.addr1  : bus.addr0;
          mem_din_d  = pick ? bus.wdata1 : bus.wdata0;
        end
      end

      // The memory samples the command at the end of this cycle; mem_en_q
      // still remembers whether it was a write.
      ISSUE: state_d = mem_en_q ? IDLE : WAIT;

      WAIT: begin
        state_d = IDLE;
        if (win_q) begin
          rdata1_d  = bus.mem_dout;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = bus.mem_dout;
          rvalid0_d = 1'b1;
        end
        if (!bus.mem_valid) rd_err_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    // Registered busy that lines up with the state it describes.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      win_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      busy_q     <= busy_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.busy     = busy_q;
  assign bus.rd_err   = rd_err_q;

endmodule

// File: doc/mem_arb2.md
# mem_arb2

Two-requester round-robin arbiter and sequencer for the single-port 16x32 register memory (EN high = write, EN low = registered read, Valid_out flags read data).
- Accepts one command at a time from either of two requesters.
- Drives the memory's EN/Address/Data_in from registers.
- Returns read data to the requester that issued the read, with a one-cycle valid pulse.
- Sits between the memory and the two datapath clients that share it.

## Interface
Parameters:
- DATA_WIDTH, 32, data width; must match memory.
- ADDR_WIDTH, 4, address width; must match memory.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req0 / req1  in  1  command request from requester 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read; qualified by reqN.
- addr0 / addr1  in  ADDR_WIDTH  command address.
- wdata0 / wdata1  in  DATA_WIDTH  write data.
- gnt0 / gnt1  out  1  command accepted; one-cycle pulse.
- rvalid0 / rvalid1  out  1  read data valid; one-cycle pulse.
- rdata0 / rdata1  out  DATA_WIDTH  read data; holds last value.
- mem_en  out  1  to memory EN.
- mem_addr  out  ADDR_WIDTH  to memory Address.
- mem_din  out  DATA_WIDTH  to memory Data_in.
- mem_dout  in  DATA_WIDTH  from memory Data_out.
- mem_valid  in  1  from memory Valid_out.
- busy  out  1  high whenever the state is not IDLE.
- rd_err  out  1  sticky; set if mem_valid is 0 when read data is captured.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Samples req0/req1 each edge.
  - If any is high, selects the winner, latches its we/addr/wdata into mem_en/mem_addr/mem_din, records the winner id and goes to ISSUE.
  - If neither is high, stays in IDLE with mem_en = 0.
- Arbitration:
  - Round-robin priority pointer, initialised to requester 0 at reset.
  - Only one request high: that requester wins regardless of the pointer.
  - Both high: the pointer's requester wins.
  - After every grant the pointer moves to the requester that did not win.
- ISSUE:
  - gntN is high for exactly this cycle, for the winner only.
  - The memory samples the command at the next edge.
  - Write: go to IDLE, with mem_en cleared on the same edge.
  - Read: go to WAIT, with mem_en at 0.
- WAIT:
  - At the next edge, mem_dout is captured into rdataN of the winner and rvalidN pulses for one cycle; state goes to IDLE.
  - If mem_valid is 0 at capture, rd_err sets and stays set until RST.
- req is ignored in ISSUE and WAIT. A requester drops or changes reqN after sampling gntN high; a request held after gnt is treated as a new command.
- mem_en is high only in ISSUE for a write. In every other cycle mem_en = 0, so the memory performs harmless reads. mem_addr and mem_din hold their last values.
- Non-winning rdata is unchanged; at most one gnt and at most one rvalid are high in any cycle.

## Timing
- Reset values: every output 0; state IDLE; pointer at requester 0. Asserting RST mid-transaction abandons it: no gnt, no rvalid, memory left untouched if the write had not yet been sampled.
- Write, with req seen at edge N:
  - gnt high in cycle N..N+1; memory write at edge N+1.
  - Next command sampled at edge N+2, giving 2-cycle throughput.
- Read, with req seen at edge N:
  - gnt high in cycle N..N+1.
  - Memory Data_out updates at N+1.
  - rdata/rvalid update at edge N+2; rvalid high in cycle N+2..N+3.
  - Next command sampled at edge N+3, giving 3-cycle throughput.
- A read issued after a write to the same address returns the new data, since the write completes before the read issues.
- busy is registered and matches the state (not IDLE).

## Test plan
- Reset, then idle 5 cycles:
  - All outputs 0, mem_en 0, busy 0.
- Write and read back on requester 0:
  - req0 write addr 3 data 0xDEADBEEF, then req0 read addr 3.
  - gnt0 pulses twice.
  - rvalid0 pulses 2 cycles after the read grant with rdata0 = 0xDEADBEEF; rdata1 and rvalid1 stay 0.
- Simultaneous contention:
  - req0 and req1 both held high with writes to addr 0 and addr 15 right after reset.
  - Grant order 0, 1, 0, 1 at a 2-cycle spacing; memory[15] receives wdata1.
- Address wrap:
  - req1 writes 0x1 to addr 15, then 0x2 to addr 0, then reads both.
  - Returns 0x1 and 0x2; no aliasing.
- Reset mid-operation:
  - Assert RST in ISSUE of a write to addr 5 (value 0xAAAA5555), before edge N+1.
  - No gnt follows; a later read of addr 5 does not return 0xAAAA5555.
  - All outputs are 0 while RST is high.
- rd_err path:
  - Force mem_valid to 0 during WAIT.
  - rd_err rises and stays 1 until RST, while rvalid still pulses.
